// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first digit-serial compare with early exit and start/done handshake
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 signed_mode,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 eq,
    output logic                                 gt,
    output logic                                 lt,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]     cycles
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] ra, rb;
    logic [CW-1:0] idx;
    logic [DIGIT-1:0] da, db;
    logic accept, diff, last;

    // operands shift left so the digit under test is always at the top
    assign da = ra[WIDTH-1 -: DIGIT];
    assign db = rb[WIDTH-1 -: DIGIT];
    assign diff = da != db;
    assign last = idx == CW'(NDIG - 1);
    assign accept = start && state != SCAN;

    always_comb begin
        state_nx = accept ? SCAN :
                   (state == SCAN && (diff || last)) ? DONE :
                   (state == DONE) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            cycles <= '0;
        end else begin
            busy <= state_nx == SCAN;
            done <= state_nx == DONE;
            if (accept) begin
                // flipping the sign bits maps two's-complement order onto unsigned order
                ra     <= a ^ {signed_mode, {(WIDTH-1){1'b0}}};
                rb     <= b ^ {signed_mode, {(WIDTH-1){1'b0}}};
                idx    <= '0;
                eq     <= 1'b0;
                gt     <= 1'b0;
                lt     <= 1'b0;
                cycles <= '0;
            end else if (state == SCAN) begin
                if (diff || last) begin
                    eq     <= !diff;
                    gt     <= da > db;
                    lt     <= da < db;
                    cycles <= idx + CW'(1);
                end else begin
                    ra  <= ra << DIGIT;
                    rb  <= rb << DIGIT;
                    idx <= idx + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: random and directed checks against an arithmetic reference model
module tb_serial_magnitude_comparator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed_mode = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic busy0, done0, eq0, gt0, lt0;
    logic [3:0] cycles0;
    logic busy1, done1, eq1, gt1, lt1;
    logic [4:0] cycles1;
    int n_tests = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0), .cycles(cycles0));

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1), .cycles(cycles1));

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                                  input int dig, output int e, output int g, output int l, output int c);
        int va, vb;
        logic [15:0] x;
        va = sm ? int'($signed(av)) : int'(av);
        vb = sm ? int'($signed(bv)) : int'(bv);
        e = int'(va == vb);
        g = int'(va > vb);
        l = int'(va < vb);
        x = av ^ bv;
        c = 16 / dig;
        for (int p = 0; p < 16; p++)
            if (x[p]) c = (15 - p) / dig + 1;
    endfunction

    task automatic compare(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        int e, g, l, c, e1, g1, l1, c1, t0;
        bit got0 = 0, got1 = 0;
        model(av, bv, sm, 2, e, g, l, c);
        model(av, bv, sm, 1, e1, g1, l1, c1);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy0), 1);
        for (int k = 0; k < 40 && !(got0 && got1); k++) begin
            @(posedge clk);
            #1;
            if (done0 && !got0) begin
                got0 = 1;
                check("latency", cyc - t0, c);
                check("eq", int'(eq0), e);
                check("gt", int'(gt0), g);
                check("lt", int'(lt0), l);
                check("cycles", int'(cycles0), c);
                check("busy_at_done", int'(busy0), 0);
            end
            if (done1 && !got1) begin
                got1 = 1;
                check("d1_latency", cyc - t0, c1);
                check("d1_eq", int'(eq1), e1);
                check("d1_gt", int'(gt1), g1);
                check("d1_lt", int'(lt1), l1);
                check("d1_cycles", int'(cycles1), c1);
            end
        end
        if (!got0) check("done_timeout", 0, 1);
        if (!got1) check("d1_done_timeout", 0, 1);
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = done0;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin
        int t0;
        bit seen;
        logic [15:0] ra, rb;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_flags", int'({eq0, gt0, lt0}), 0);
        check("rst_cycles", int'(cycles0), 0);
        rst_n = 1'b1;

        compare(16'h8000, 16'h7FFF, 1'b0);
        compare(16'h1234, 16'h1234, 1'b0);
        compare(16'h8000, 16'h0001, 1'b1);
        compare(16'h8000, 16'h0001, 1'b0);
        compare(16'h0003, 16'h0002, 1'b0);
        compare(16'h0001, 16'h0000, 1'b0);
        compare(16'hFFFF, 16'hFFFF, 1'b1);

        // second start during SCAN must be ignored, then start held through DONE
        @(negedge clk);
        a = 16'h00FF; b = 16'h0100; signed_mode = 1'b0; start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = '0; b = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen);
        check("hs_latency", cyc - t0, 4);
        check("hs_lt", int'({eq0, gt0, lt0}), 1);
        check("hs_cycles", int'(cycles0), 4);
        start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", int'(busy0), 1);
        check("b2b_cleared", int'({eq0, gt0, lt0}), 0);
        check("b2b_cycles_cleared", int'(cycles0), 0);
        wait_done(seen);
        check("b2b_latency", cyc - t0, 8);
        check("b2b_eq", int'({eq0, gt0, lt0}), 4);
        check("b2b_cycles", int'(cycles0), 8);
        repeat (20) @(negedge clk);

        // reset in the third SCAN cycle
        a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy", int'(busy0), 1);
        @(negedge clk);
        check("mid_done", int'(done0), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy0), 0);
        check("abort_done", int'(done0), 0);
        check("abort_flags", int'({eq0, gt0, lt0}), 0);
        check("abort_cycles", int'(cycles0), 0);
        check("abort_d1", int'({busy1, done1, eq1, gt1, lt1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", int'({busy0, done0}), 0);
        end
        compare(16'h8000, 16'h7FFF, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            compare(ra, rb, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
